soc_gpio_pwm_capture: RTL and testbench
=======================================

# soc_gpio_pwm_capture

Avalon-MM slave peripheral that measures an external PWM/tach signal (period and high time) and presents the results as read-only registers with a maskable interrupt. It is the receive-side counterpart of the PWM output/prescaler registers in the SoC GPIO subsystem. It sits on the same Qsys/Avalon bus as the other GPIO PIOs, with `in_port` wired to an FPGA pin (fan tach or sensor PWM).

## Interface

Parameters:
- `CNT_W`, default 32: width of the tick counter and the PERIOD/HIGH registers (8..32).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `address`  in  3  word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read mux, zero wait states, no read side effects.
- `in_port`  in  1  asynchronous PWM input.
- `irq`  out  1  level interrupt, `CTRL.irq_en & STATUS.valid`.

## Operation

Register map (word addresses):
- 0 CTRL, R/W: bit0 `enable`, bit1 `irq_en`; other bits read 0.
- 1 PRESCALE, R/W, 32 bits: one tick every PRESCALE+1 clk cycles.
- 2 PERIOD, RO, CNT_W bits zero-extended: ticks between the last two rising edges.
- 3 HIGH, RO: ticks from that period's rising edge to its falling edge.
- 4 STATUS:
  - bit0 `valid`, W1C.
  - bit1 `ovf`, W1C.
  - bit2 `level`, RO: synchronized input.
  - Other bits read 0.
- 5..7: read 0; writes ignored.
- Writes to RO registers are ignored.

Datapath:
- 2-FF synchronizer on `in_port` (`s1`→`s2`), plus a `prev` register. `rise = s2 & ~prev`; `fall = ~s2 & prev`.
- Prescaler `pre_cnt`. `tick = enable && (pre_cnt == PRESCALE)`. `pre_cnt` wraps to 0 on tick and is cleared on `rise`.
- Tick counter `cnt` increments on tick and saturates at 2^CNT_W−1. Attempting to increment past saturation sets `ovf`.
- `cnt_next = sat(cnt + tick)`.
- State machine:
  - IDLE (enable=0): `cnt` and `pre_cnt` held at 0; `armed`=0.
  - ARMING (enable=1, armed=0): waits for the first `rise`. On that rise, clear `cnt`/`pre_cnt` and set `armed`. No capture occurs.
  - MEASURE (armed=1):
    - On `fall`: `high_snap <= cnt_next`.
    - On `rise`: `PERIOD <= cnt_next`, `HIGH <= high_snap`, `valid <= 1`, clear `cnt`/`pre_cnt`.
- With S = PRESCALE+1, PERIOD = floor(P/S) and HIGH = floor(H/S), where P and H are in clk cycles.
- If no fall occurs within a period (input stuck high), HIGH = PERIOD.
- Clearing `enable` returns the block to IDLE on the next clk edge. PERIOD, HIGH and STATUS are retained.
- A PRESCALE write takes effect immediately. The current measurement may be inaccurate; software discards the next sample.
- Simultaneous events:
  - A capture and a W1C of `valid` in the same cycle: set wins.
  - A saturation and a W1C of `ovf` in the same cycle: set wins.

## Timing

- Reset values: CTRL=0, PRESCALE=0, PERIOD=0, HIGH=0, STATUS.valid/ovf=0, `s1`/`s2`/`prev`=0, `cnt`=0, `irq`=0, `readdata`=0.
- Edge latency: an `in_port` change sampled at clk edge E0 reaches `s2` at E1 and updates PERIOD/HIGH/`valid` at E2. These values are readable after E2.
- `irq` follows `valid` combinationally with no extra cycle; it deasserts the cycle after a W1C write.
- Register writes take effect at the clk edge of the write cycle. `readdata` reflects the new value from the next cycle.
- Minimum measurable input pulse: 2 clk cycles high and 2 low. Shorter pulses may be missed.

## Structure

- Shared package (or header) holds:
  - Register address constants: `PWMCAP_CTRL`=0, `PRESCALE`=1, `PERIOD`=2, `HIGH`=3, `STATUS`=4.
  - CTRL/STATUS bit-index constants.
  - The state encoding IDLE/ARMING/MEASURE.
- One sub-module, `pwm_cap_sync_edge`: the 2-FF synchronizer plus edge detector, with outputs `level`, `rise`, `fall`. It is reusable by other GPIO inputs.
- Everything else (register file, prescaler, counter, FSM) lives in the top module.

## Test plan

- Basic measurement: PRESCALE=0, CTRL=3, `in_port` period 100 clk with 25 high → after the second rise, PERIOD=100, HIGH=25, STATUS.valid=1, `irq`=1. W1C 0x1 to STATUS → `irq`=0 the next cycle.
- Prescaling: PRESCALE=9, period 1000 clk with 300 high → PERIOD=100, HIGH=30. Repeat with PRESCALE=6 → PERIOD=142, HIGH=42.
- Arming: enable the block, then apply exactly one rising edge → `valid` stays 0 and PERIOD is unchanged. After the second rising edge → `valid`=1.
- Overflow (CNT_W=8): PRESCALE=0, arm, then hold the input low for 300 clk and rise → PERIOD=255, STATUS.ovf=1. A W1C write to `ovf` in the same cycle as a saturating increment leaves `ovf`=1.
- Collision and disable:
  - Issue a W1C of `valid` in the exact capture cycle → `valid`=1.
  - Clear `enable` mid-period → `cnt` returns to 0 and PERIOD/HIGH are retained. Re-enabling requires a fresh arm.
- Reset mid-operation: assert `reset_n` low while MEASURE is active with `valid`=1 → all registers, `irq` and `readdata` are 0 immediately (asynchronously). After release, no capture occurs until CTRL is written.

Source files
------------

// File: rtl/soc_gpio_pwm_capture_pkg.sv
// Shared definitions for the PWM/tach capture peripheral: register map,
// CTRL/STATUS bit positions, FSM encoding and a STATUS word packer.
package soc_gpio_pwm_capture_pkg;

  localparam logic [2:0] PWMCAP_CTRL     = 3'd0;
  localparam logic [2:0] PWMCAP_PRESCALE = 3'd1;
  localparam logic [2:0] PWMCAP_PERIOD   = 3'd2;
  localparam logic [2:0] PWMCAP_HIGH     = 3'd3;
  localparam logic [2:0] PWMCAP_STATUS   = 3'd4;

  localparam int CTRL_ENABLE_BIT   = 32'sd0;
  localparam int CTRL_IRQ_EN_BIT   = 32'sd1;
  localparam int STATUS_VALID_BIT  = 32'sd0;
  localparam int STATUS_OVF_BIT    = 32'sd1;
  localparam int STATUS_LEVEL_BIT  = 32'sd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMING  = 2'd1,
    ST_MEASURE = 2'd2
  } pwmcap_state_e;

  function automatic logic [31:0] pack_status(input logic level,
                                              input logic ovf,
                                              input logic valid);
    logic [31:0] word;
    word = 32'd0;
    word[STATUS_VALID_BIT] = valid;
    word[STATUS_OVF_BIT]   = ovf;
    word[STATUS_LEVEL_BIT] = level;
    return word;
  endfunction

  function automatic logic [31:0] pack_ctrl(input logic irq_en,
                                            input logic enable);
    logic [31:0] word;
    word = 32'd0;
    word[CTRL_ENABLE_BIT] = enable;
    word[CTRL_IRQ_EN_BIT] = irq_en;
    return word;
  endfunction

endpackage

// File: rtl/pwm_cap_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle
// rise/fall detector on the synchronized level.
module pwm_cap_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic prev_r;

  // Synchronizer chain and previous-level history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      s1_r   <= din;
      s2_r   <= s1_r;
      prev_r <= s2_r;
    end
  end

  assign level = s2_r;
  assign rise  = s2_r & ~prev_r;
  assign fall  = ~s2_r & prev_r;

endmodule

// File: rtl/soc_gpio_pwm_capture.sv
// Avalon-MM slave that measures period and high time of an external PWM/tach
// signal in prescaled ticks and raises a maskable level interrupt per capture.
module soc_gpio_pwm_capture
  import soc_gpio_pwm_capture_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             level_s;
  logic             rise_s;
  logic             fall_s;

  logic             wr_s;
  logic             wr_ctrl_s;
  logic             wr_pre_s;
  logic             wr_status_s;

  logic             ctrl_enable_r;
  logic             ctrl_irq_en_r;
  logic [31:0]      prescale_r;
  logic [31:0]      pre_cnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_r;
  logic [CNT_W-1:0] high_snap_r;
  logic             fall_seen_r;
  logic             valid_r;
  logic             ovf_r;

  logic             tick_s;
  logic             cnt_sat_s;
  logic             sat_hit_s;

  pwmcap_state_e    state_r;
  pwmcap_state_e    state_nx_s;
  logic             clr_cnt_s;
  logic             run_cnt_s;
  logic             capture_s;
  logic             snap_s;

  pwm_cap_sync_edge u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .level   (level_s),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  assign wr_s        = chipselect & ~write_n;
  assign wr_ctrl_s   = wr_s && (address == PWMCAP_CTRL);
  assign wr_pre_s    = wr_s && (address == PWMCAP_PRESCALE);
  assign wr_status_s = wr_s && (address == PWMCAP_STATUS);

  assign tick_s     = ctrl_enable_r && (pre_cnt_r == prescale_r);
  assign cnt_sat_s  = (cnt_r == CNT_MAX);
  assign cnt_next_s = (tick_s && !cnt_sat_s) ? (cnt_r + CNT_ONE) : cnt_r;
  // An increment attempted while already at the top is what flags overflow.
  assign sat_hit_s  = run_cnt_s && tick_s && cnt_sat_s;

  // Software-writable control and prescaler registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable_r <= 1'b0;
      ctrl_irq_en_r <= 1'b0;
      prescale_r    <= 32'd0;
    end else begin
      if (wr_ctrl_s) begin
        ctrl_enable_r <= writedata[CTRL_ENABLE_BIT];
        ctrl_irq_en_r <= writedata[CTRL_IRQ_EN_BIT];
      end
      if (wr_pre_s) begin
        prescale_r <= writedata;
      end
    end
  end

  // Measurement state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and datapath controls; a disabled block is forced idle.
  always_comb begin
    state_nx_s = state_r;
    clr_cnt_s  = 1'b0;
    run_cnt_s  = 1'b0;
    capture_s  = 1'b0;
    snap_s     = 1'b0;
    if (!ctrl_enable_r) begin
      state_nx_s = ST_IDLE;
      clr_cnt_s  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_ARMING: begin
          clr_cnt_s = 1'b1;
          if (rise_s) begin
            state_nx_s = ST_MEASURE;
          end else begin
            state_nx_s = ST_ARMING;
          end
        end
        ST_MEASURE: begin
          run_cnt_s = 1'b1;
          capture_s = rise_s;
          snap_s    = fall_s;
        end
        default: begin
          state_nx_s = ST_IDLE;
          clr_cnt_s  = 1'b1;
        end
      endcase
    end
  end

  // Prescaler and saturating tick counter, restarted on every rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_r <= 32'd0;
      cnt_r     <= '0;
    end else if (clr_cnt_s || capture_s) begin
      pre_cnt_r <= 32'd0;
      cnt_r     <= '0;
    end else if (run_cnt_s) begin
      pre_cnt_r <= tick_s ? 32'd0 : (pre_cnt_r + 32'd1);
      cnt_r     <= cnt_next_s;
    end else begin
      pre_cnt_r <= pre_cnt_r;
      cnt_r     <= cnt_r;
    end
  end

  // Falling-edge snapshot and result capture; with no fall seen, HIGH spans the period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_r    <= '0;
      high_r      <= '0;
      high_snap_r <= '0;
      fall_seen_r <= 1'b0;
    end else if (capture_s) begin
      period_r    <= cnt_next_s;
      high_r      <= fall_seen_r ? high_snap_r : cnt_next_s;
      fall_seen_r <= 1'b0;
    end else if (snap_s) begin
      high_snap_r <= cnt_next_s;
      fall_seen_r <= 1'b1;
    end else if (clr_cnt_s) begin
      fall_seen_r <= 1'b0;
    end else begin
      fall_seen_r <= fall_seen_r;
    end
  end

  // Sticky status flags; a hardware set beats a same-cycle W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (capture_s) begin
        valid_r <= 1'b1;
      end else if (wr_status_s && writedata[STATUS_VALID_BIT]) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      if (sat_hit_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s && writedata[STATUS_OVF_BIT]) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Zero-wait-state read mux without side effects.
  always_comb begin
    readdata = 32'd0;
    case (address)
      PWMCAP_CTRL:     readdata = pack_ctrl(ctrl_irq_en_r, ctrl_enable_r);
      PWMCAP_PRESCALE: readdata = prescale_r;
      PWMCAP_PERIOD:   readdata[CNT_W-1:0] = period_r;
      PWMCAP_HIGH:     readdata[CNT_W-1:0] = high_r;
      PWMCAP_STATUS:   readdata = pack_status(level_s, ovf_r, valid_r);
      default:         readdata = 32'd0;
    endcase
  end

  assign irq = ctrl_irq_en_r & valid_r;

endmodule

// File: tb/tb_soc_gpio_pwm_capture.sv
// Scoreboard bench for soc_gpio_pwm_capture: reads push expected values from a
// period/high arithmetic model; a negedge monitor pops and compares them.
module tb_soc_gpio_pwm_capture;
  import soc_gpio_pwm_capture_pkg::*;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        in_port;
  logic        irq;

  always #5 clk = ~clk;

  soc_gpio_pwm_capture #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;

  // reference model state
  logic        m_en, m_irq_en, m_valid, m_ovf;
  logic [31:0] m_pre, m_period, m_high;

  always @(negedge clk) begin
    if (chipselect === 1'b1 && write_n === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: addr=%0d data=0x%08h with no expected entry", address, readdata);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        if (readdata !== mon_e.data || irq !== mon_e.irq) begin
          n_fail++;
          $display("FAIL %s: got data=0x%08h irq=%b, expected data=0x%08h irq=%b",
                   mon_nm, readdata, irq, mon_e.data, mon_e.irq);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status();
    return {29'd0, in_port, m_ovf, m_valid};
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycles(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] d, input string nm);
    exp_t e;
    e.data = d;
    e.irq  = m_irq_en & m_valid;
    exp_q.push_back(e);
    name_q.push_back(nm);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    cycles(1);
    chipselect = 1'b0;
  endtask

  task automatic wr_ctrl(input logic ie, input logic en);
    logic [31:0] r;
    r      = $urandom();
    r[1:0] = {ie, en};
    bus_write(PWMCAP_CTRL, r);
    m_en     = en;
    m_irq_en = ie;
  endtask

  task automatic wr_pre(input logic [31:0] v);
    bus_write(PWMCAP_PRESCALE, v);
    m_pre = v;
  endtask

  task automatic w1c(input logic [1:0] mask);
    bus_write(PWMCAP_STATUS, {29'd0, 1'b1, mask});
    if (mask[0]) m_valid = 1'b0;
    if (mask[1]) m_ovf = 1'b0;
  endtask

  // a completed period of p clk cycles with h high, measured at the current prescale
  task automatic record(input int p, input int h);
    int s, q, qh;
    s  = int'(m_pre) + 1;
    q  = p / s;
    qh = h / s;
    m_period = 32'((q > MAXC) ? MAXC : q);
    m_high   = 32'((qh > MAXC) ? MAXC : qh);
    if (q > MAXC) m_ovf = 1'b1;
    m_valid = 1'b1;
  endtask

  task automatic gen_period(input int h, input int l);
    in_port = 1'b1;
    cycles(h);
    in_port = 1'b0;
    cycles(l);
  endtask

  task automatic rise_hold();
    in_port = 1'b1;
    cycles(3);
  endtask

  task automatic settle();
    in_port = 1'b0;
    cycles(3);
  endtask

  task automatic check_all(input string tag);
    bus_read(PWMCAP_CTRL,     {30'd0, m_irq_en, m_en}, {tag, "_ctrl"});
    bus_read(PWMCAP_PRESCALE, m_pre,                   {tag, "_prescale"});
    bus_read(PWMCAP_PERIOD,   m_period,                {tag, "_period"});
    bus_read(PWMCAP_HIGH,     m_high,                  {tag, "_high"});
    bus_read(PWMCAP_STATUS,   exp_status(),            {tag, "_status"});
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_irq_en = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
    m_pre = 32'd0; m_period = 32'd0; m_high = 32'd0;
  endtask

  logic [2:0] ro_tbl [5] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  initial begin
    exp_t er;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = 32'd0; in_port = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycles(1);

    for (int a = 0; a < 8; a++) bus_read(3'(a), 32'd0, "reset_value");
    wr_pre(32'hDEADBEEF);
    bus_read(PWMCAP_PRESCALE, m_pre, "prescale_rw");
    wr_pre(32'd0);

    // basic measurement: 100 clk period, 25 high
    wr_ctrl(1'b1, 1'b1);
    cycles(2);
    gen_period(25, 75);
    rise_hold();
    record(100, 25);
    check_all("basic");
    w1c(2'b01);
    bus_read(PWMCAP_STATUS, exp_status(), "basic_w1c_irq_drop");
    settle();

    // prescaling, S=10 and S=7
    wr_ctrl(1'b0, 1'b0); wr_pre(32'd9); wr_ctrl(1'b1, 1'b1);
    cycles(2);
    gen_period(300, 700);
    rise_hold();
    record(1000, 300);
    check_all("pre9");
    settle();
    wr_ctrl(1'b0, 1'b0); wr_pre(32'd6); wr_ctrl(1'b1, 1'b1);
    cycles(2);
    gen_period(300, 700);
    rise_hold();
    record(1000, 300);
    check_all("pre6");
    settle();

    // arming: the first rise never captures
    wr_ctrl(1'b0, 1'b0); wr_pre(32'd0); w1c(2'b11); wr_ctrl(1'b0, 1'b1);
    cycles(2);
    in_port = 1'b1; cycles(5);
    in_port = 1'b0; cycles(5);
    bus_read(PWMCAP_STATUS, exp_status(), "arm_no_valid");
    bus_read(PWMCAP_PERIOD, m_period, "arm_period_kept");
    rise_hold();
    record(12, 5);
    check_all("arm_second_rise");
    settle();

    // overflow, then W1C of ovf colliding with a saturating increment
    wr_ctrl(1'b0, 1'b0); w1c(2'b11); wr_ctrl(1'b1, 1'b1);
    cycles(2);
    gen_period(5, 300);
    rise_hold();
    record(305, 5);
    check_all("ovf");
    cycles(300);
    bus_write(PWMCAP_STATUS, 32'd2);
    bus_read(PWMCAP_STATUS, exp_status(), "ovf_set_wins");
    wr_ctrl(1'b1, 1'b0);
    w1c(2'b10);
    bus_read(PWMCAP_STATUS, exp_status(), "ovf_w1c");
    settle();

    // W1C of valid in the exact capture cycle
    wr_ctrl(1'b0, 1'b0); w1c(2'b11); wr_ctrl(1'b1, 1'b1);
    cycles(2);
    gen_period(6, 6);
    in_port = 1'b1;
    cycles(2);
    bus_write(PWMCAP_STATUS, 32'd1);
    cycles(2);
    record(12, 6);
    check_all("valid_set_wins");

    // disable mid-period keeps results; re-enable needs a fresh arm
    in_port = 1'b0; cycles(4);
    wr_ctrl(1'b1, 1'b0);
    cycles(2);
    in_port = 1'b1; cycles(5);
    in_port = 1'b0; cycles(5);
    check_all("disabled");
    w1c(2'b11);
    wr_ctrl(1'b1, 1'b1);
    cycles(2);
    in_port = 1'b1; cycles(4);
    in_port = 1'b0; cycles(5);
    bus_read(PWMCAP_STATUS, exp_status(), "rearm_no_valid");
    cycles(4);
    rise_hold();
    record(14, 4);
    check_all("rearm");

    // asynchronous reset while measuring with valid set
    er.data = 32'd0;
    er.irq  = 1'b0;
    exp_q.push_back(er);
    name_q.push_back("reset_async");
    address = PWMCAP_STATUS; chipselect = 1'b1; write_n = 1'b1;
    reset_n = 1'b0;
    cycles(1);
    chipselect = 1'b0;
    model_reset();
    in_port = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
    check_all("after_reset");
    gen_period(5, 5);
    gen_period(5, 5);
    rise_hold();
    check_all("reset_no_capture");
    settle();
    wr_ctrl(1'b1, 1'b1);
    cycles(2);
    gen_period(20, 30);
    rise_hold();
    record(50, 20);
    check_all("reset_recover");
    settle();

    // randomized trials against the arithmetic model
    for (int t = 0; t < 25; t++) begin
      int s, h0, l0, h, l;
      logic [2:0] ro_a;
      logic [31:0] ro_exp;
      logic [1:0] mask;
      s  = $urandom_range(8, 1);
      h0 = $urandom_range(250, 2); l0 = $urandom_range(250, 2);
      h  = $urandom_range(250, 2); l  = $urandom_range(250, 2);
      wr_ctrl(1'b0, 1'b0);
      wr_pre(32'(s - 1));
      w1c(2'b11);
      wr_ctrl(1'($urandom_range(1, 0)), 1'b1);
      cycles(2);
      gen_period(h0, l0);
      gen_period(h, l);
      record(h0 + l0, h0);
      rise_hold();
      record(h + l, h);
      ro_a = ro_tbl[$urandom_range(4, 0)];
      bus_write(ro_a, $urandom());
      ro_exp = (ro_a == 3'd2) ? m_period : ((ro_a == 3'd3) ? m_high : 32'd0);
      bus_read(ro_a, ro_exp, "ro_write_ignored");
      check_all("rand");
      mask = 2'($urandom_range(3, 0));
      w1c(mask);
      bus_read(PWMCAP_STATUS, exp_status(), "rand_w1c");
      settle();
    end

    cycles(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected reads left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
